// File: rtl/video_cfg_if.sv
// Signal bundle between the keyboard/board/video side and video_cfg_ctrl.
// The master drives requests and vsync; the slave returns video config and core reset.
interface video_cfg_if;
  logic       kbd_scanlines_i;
  logic       kbd_scandbl_i;
  logic       kbd_reset_i;
  logic [1:0] btn_n_i;
  logic       vs_i;
  logic [1:0] scanlines_o;
  logic       scandoubler_o;
  logic       core_reset_o;
  logic       busy_o;

  modport master (
    output kbd_scanlines_i, kbd_scandbl_i, kbd_reset_i, btn_n_i, vs_i,
    input  scanlines_o, scandoubler_o, core_reset_o, busy_o
  );

  modport slave (
    input  kbd_scanlines_i, kbd_scandbl_i, kbd_reset_i, btn_n_i, vs_i,
    output scanlines_o, scandoubler_o, core_reset_o, busy_o
  );
endinterface

// File: rtl/video_cfg_ctrl.sv
// Video config controller: debounced buttons and keyboard pulses queue scanline/scandoubler
// changes that land on vsync (or a timeout), plus a retriggerable core reset hold.
//
// state | meaning
// ------+------------------------------------------------------------
// HOLD  | core_reset_o high, hold counter counting up to RESET_HOLD-1
// RUN   | core running, waiting for kbd_reset_i
module video_cfg_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1024,
  parameter int RESET_HOLD      = 4096,
  parameter int VS_TIMEOUT      = 1 << 20,
  parameter bit SD_INIT         = 1'b1
) (
  input logic        clk,
  input logic        reset,
  video_cfg_if.slave bus
);

  localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
  localparam int WAIT_W = (VS_TIMEOUT > 1) ? $clog2(VS_TIMEOUT) : 1;

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(VS_TIMEOUT - 1);

  typedef enum logic {RUN = 1'b0, HOLD = 1'b1} state_t;

  state_t state, state_nxt;
  logic [HOLD_W-1:0] hold_cnt, hold_nxt;

  logic [1:0]      btn_sync1, btn_sync2, db_lvl;
  logic [DB_W-1:0] db_cnt [2];
  logic [1:0]      press;

  logic            vs_q;
  logic            pend_sl, pend_sd;
  logic            pend_sl_nxt, pend_sd_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic [1:0]      scanlines;
  logic            scandoubler;
  logic            busy;
  logic            vs_edge, any_pend, timeout, apply;
  logic            req_sl, req_sd;

  // Debounce counters are down-counters; acceptance happens on the sample after reaching zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      btn_sync1 <= 2'b11;
      btn_sync2 <= 2'b11;
      db_lvl    <= 2'b11;
      for (int i = 0; i < 2; i++) db_cnt[i] <= DB_LAST;
    end else begin
      btn_sync1 <= bus.btn_n_i;
      btn_sync2 <= btn_sync1;
      for (int i = 0; i < 2; i++) begin
        if (btn_sync2[i] == db_lvl[i]) begin
          db_cnt[i] <= DB_LAST;
        end else if (db_cnt[i] == '0) begin
          db_lvl[i] <= btn_sync2[i];
          db_cnt[i] <= DB_LAST;
        end else begin
          db_cnt[i] <= db_cnt[i] - 1'b1;
        end
      end
    end
  end

  always_comb begin
    press = 2'b00;
    for (int i = 0; i < 2; i++)
      press[i] = (btn_sync2[i] != db_lvl[i]) && (db_cnt[i] == '0) && !btn_sync2[i];
  end

  assign req_sl   = bus.kbd_scanlines_i | press[0];
  assign req_sd   = bus.kbd_scandbl_i | press[1];
  assign vs_edge  = bus.vs_i & ~vs_q;
  assign any_pend = pend_sl | pend_sd;
  assign timeout  = any_pend && (wait_cnt == WAIT_LAST);
  assign apply    = any_pend && (vs_edge || timeout);

  // A request on the application cycle survives into the next batch.
  assign pend_sl_nxt = req_sl | (pend_sl & ~apply);
  assign pend_sd_nxt = req_sd | (pend_sd & ~apply);

  always_ff @(posedge clk) begin
    if (reset) begin
      vs_q        <= 1'b0;
      pend_sl     <= 1'b0;
      pend_sd     <= 1'b0;
      wait_cnt    <= '0;
      scanlines   <= 2'd0;
      scandoubler <= SD_INIT;
    end else begin
      vs_q    <= bus.vs_i;
      pend_sl <= pend_sl_nxt;
      pend_sd <= pend_sd_nxt;
      if (!any_pend || apply) wait_cnt <= '0;
      else                    wait_cnt <= wait_cnt + 1'b1;
      if (apply && pend_sl) scanlines   <= scanlines + 2'd1;
      if (apply && pend_sd) scandoubler <= ~scandoubler;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= HOLD;
      hold_cnt <= '0;
      busy     <= 1'b1;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_nxt;
      busy     <= pend_sl_nxt | pend_sd_nxt | (state_nxt == HOLD);
    end
  end

  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    case (state)
      HOLD: begin
        if (bus.kbd_reset_i) begin
          hold_nxt = '0;
        end else if (hold_cnt == HOLD_LAST) begin
          state_nxt = RUN;
          hold_nxt  = '0;
        end else begin
          hold_nxt = hold_cnt + 1'b1;
        end
      end
      RUN: begin
        if (bus.kbd_reset_i) begin
          state_nxt = HOLD;
          hold_nxt  = '0;
        end
      end
      default: begin
        state_nxt = HOLD;
        hold_nxt  = '0;
      end
    endcase
  end

  assign bus.scanlines_o   = scanlines;
  assign bus.scandoubler_o = scandoubler;
  assign bus.core_reset_o  = (state == HOLD);
  assign bus.busy_o        = busy;

endmodule

// File: tb/tb_video_cfg_ctrl.sv
// Directed bench for video_cfg_ctrl with small parameters; expected values are hand-derived.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_video_cfg_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;

  video_cfg_if bus ();

  video_cfg_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .RESET_HOLD(8),
    .VS_TIMEOUT(100),
    .SD_INIT(1'b1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_sl();
    bus.kbd_scanlines_i = 1'b1; tick(); bus.kbd_scanlines_i = 1'b0;
  endtask

  task automatic pulse_sd();
    bus.kbd_scandbl_i = 1'b1; tick(); bus.kbd_scandbl_i = 1'b0;
  endtask

  task automatic vsync();
    bus.vs_i = 1'b1; tick(); bus.vs_i = 1'b0;
  endtask

  // Counts post-edge samples with core_reset_o high until it drops (bounded).
  task automatic hold_length(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (!bus.core_reset_o) break;
      n++;
    end
  endtask

  int n;

  initial begin
    bus.kbd_scanlines_i = 1'b0;
    bus.kbd_scandbl_i   = 1'b0;
    bus.kbd_reset_i     = 1'b0;
    bus.btn_n_i         = 2'b11;
    bus.vs_i            = 1'b0;

    // Power-on
    tick(2);
    check("rst_core_reset", bus.core_reset_o, 1);
    check("rst_busy", bus.busy_o, 1);
    check("rst_scanlines", bus.scanlines_o, 0);
    check("rst_scandoubler", bus.scandoubler_o, 1);
    reset = 1'b0;
    hold_length(n);
    check("poweron_hold_len", n + 1, 8);
    check("poweron_busy_idle", bus.busy_o, 0);

    // Scanline wrap 1,2,3,0
    for (int i = 0; i < 4; i++) begin
      pulse_sl();
      check("wrap_busy_pending", bus.busy_o, 1);
      tick(2);
      check("wrap_held_before_vs", bus.scanlines_o, i);
      vsync();
      check("wrap_value", bus.scanlines_o, (i + 1) % 4);
      check("wrap_busy_clear", bus.busy_o, 0);
      tick();
    end

    // Collapse: 3 scanline + 1 scandoubler requests, one vsync
    pulse_sl(); tick(); pulse_sl(); pulse_sd(); pulse_sl(); tick(3);
    check("collapse_busy_before", bus.busy_o, 1);
    vsync();
    check("collapse_scanlines", bus.scanlines_o, 1);
    check("collapse_scandoubler", bus.scandoubler_o, 0);
    check("collapse_busy_after", bus.busy_o, 0);
    tick(2);
    vsync();
    check("collapse_no_second", bus.scanlines_o, 1);

    // Debounce: 3-cycle press is rejected
    tick();
    bus.btn_n_i = 2'b10; tick(3); bus.btn_n_i = 2'b11;
    tick(10);
    check("short_press_busy", bus.busy_o, 0);
    vsync();
    check("short_press_scanlines", bus.scanlines_o, 1);
    // Long press accepted, then a bounce after application raises nothing
    tick();
    bus.btn_n_i = 2'b10; tick(8);
    check("long_press_busy", bus.busy_o, 1);
    vsync();
    check("long_press_scanlines", bus.scanlines_o, 2);
    bus.btn_n_i = 2'b11; tick(2); bus.btn_n_i = 2'b10; tick(12);
    check("bounce_busy", bus.busy_o, 0);
    bus.btn_n_i = 2'b11; tick(12);
    check("release_busy", bus.busy_o, 0);
    vsync();
    check("bounce_scanlines", bus.scanlines_o, 2);

    // Timeout with vsync idle: scandoubler 0 -> 1 on the 100th edge after the request
    tick();
    pulse_sd();
    tick(99);
    check("timeout_not_yet", bus.scandoubler_o, 0);
    check("timeout_busy_pending", bus.busy_o, 1);
    tick();
    check("timeout_toggled", bus.scandoubler_o, 1);
    check("timeout_busy_clear", bus.busy_o, 0);

    // Request on the application cycle stays pending
    pulse_sl(); tick(2);
    bus.vs_i = 1'b1; bus.kbd_scanlines_i = 1'b1; tick();
    bus.vs_i = 1'b0; bus.kbd_scanlines_i = 1'b0;
    check("same_cycle_applied", bus.scanlines_o, 3);
    check("same_cycle_pending", bus.busy_o, 1);
    tick();
    vsync();
    check("same_cycle_next", bus.scanlines_o, 0);

    // Reset retrigger: pulses at K0 and K5 -> 13 cycles of core reset
    n = 0;
    for (int c = 0; c < 40; c++) begin
      bus.kbd_reset_i = (c == 0 || c == 5);
      tick();
      bus.kbd_reset_i = 1'b0;
      if (!bus.core_reset_o) break;
      n++;
    end
    check("retrigger_len", n, 13);

    // Config applies during HOLD and HOLD leaves config alone
    bus.kbd_reset_i = 1'b1; tick(); bus.kbd_reset_i = 1'b0;
    pulse_sl(); vsync();
    check("hold_cfg_scanlines", bus.scanlines_o, 1);
    check("hold_cfg_core_reset", bus.core_reset_o, 1);
    check("hold_cfg_scandoubler", bus.scandoubler_o, 1);
    tick(10);
    check("hold_cfg_done", bus.core_reset_o, 0);

    // Mid-operation reset discards pending request and partial press
    pulse_sl();
    bus.btn_n_i = 2'b01; tick(4);
    reset = 1'b1; tick();
    check("mid_rst_scanlines", bus.scanlines_o, 0);
    check("mid_rst_busy", bus.busy_o, 1);
    reset = 1'b0;
    tick(2);
    bus.btn_n_i = 2'b11;
    tick(10);
    check("mid_rst_busy_idle", bus.busy_o, 0);
    vsync();
    check("mid_rst_scanlines_kept", bus.scanlines_o, 0);
    check("mid_rst_scandoubler", bus.scandoubler_o, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/video_cfg_ctrl.md
VIDEO_CFG_CTRL -- requirements
Module: video_cfg_ctrl

Parameters
REQ-001 The block SHALL provide DEBOUNCE_CYCLES, default 1024: the number of consecutive cycles a synchronized button level must hold stable before it is accepted.
REQ-002 The block SHALL provide RESET_HOLD, default 4096: the number of cycles core_reset_o stays asserted per reset event.
REQ-003 The block SHALL provide VS_TIMEOUT, default 2^20: the number of cycles a pending request waits for vsync before it is forced.
REQ-004 The block SHALL provide SD_INIT, default 1: the reset value of scandoubler_o (1 = 15 kHz, 0 = VGA).

Interface
REQ-005 clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-006 reset, input, 1 bit: synchronous, active-high reset.
REQ-007 kbd_scanlines_i, input, 1 bit: 1-cycle keyboard pulse requesting the next scanline mode.
REQ-008 kbd_scandbl_i, input, 1 bit: 1-cycle keyboard pulse requesting a scandoubler toggle.
REQ-009 kbd_reset_i, input, 1 bit: 1-cycle keyboard pulse requesting a core reset.
REQ-010 btn_n_i, input, 2 bits: asynchronous, active-low board buttons; [0] = scanlines, [1] = scandoubler.
REQ-011 vs_i, input, 1 bit: core vertical sync, active high, asynchronous to nothing (same clk domain).
REQ-012 scanlines_o, output, 2 bits: scanline mode for the video mixer.
REQ-013 scandoubler_o, output, 1 bit: scandoubler disable (1 = 15 kHz).
REQ-014 core_reset_o, output, 1 bit: active-high reset to the arcade core.
REQ-015 busy_o, output, 1 bit: high while any request is pending or the reset hold is running.

Function
REQ-016 Each btn_n_i bit SHALL pass through a 2-flop synchronizer and then a debouncer; the accepted level changes only after DEBOUNCE_CYCLES identical synchronized samples, and any mismatch restarts the count.
REQ-017 A debounced 1->0 transition (press) SHALL raise one request; release and held levels SHALL raise nothing.
REQ-018 Scanline requests (kbd_scanlines_i OR btn[0] press) SHALL set sticky flag pend_sl; scandoubler requests (kbd_scandbl_i OR btn[1] press) SHALL set pend_sd.
REQ-019 Repeated requests of one kind while its flag is set SHALL collapse into a single application.
REQ-020 A vsync rising edge SHALL be detected as vs_i=1 while its registered value last cycle was 0.
REQ-021 On the cycle after a detected vsync edge with any flag set, the block SHALL apply all set flags together and clear them:
- pend_sl: scanlines_o increments modulo 4, wrapping 3->0.
- pend_sd: scandoubler_o inverts.
REQ-022 A wait counter SHALL run while any flag is set and clear when none is; on reaching VS_TIMEOUT the flags SHALL apply as in REQ-021 without a vsync edge.
REQ-023 A request arriving on the same cycle as an application SHALL stay pending for the next vsync edge, not be lost and not be merged.
REQ-024 The reset FSM SHALL have states RUN and HOLD:
- In HOLD, core_reset_o = 1 and a counter counts up; on reaching RESET_HOLD-1 the FSM goes to RUN.
- In RUN, core_reset_o = 0; kbd_reset_i goes to HOLD with counter = 0.
REQ-025 kbd_reset_i during HOLD SHALL restart the counter at 0.
REQ-026 Config requests SHALL be accepted and applied during HOLD; the reset FSM SHALL not clear scanlines_o, scandoubler_o or the pending flags.
REQ-027 busy_o SHALL equal (pend_sl | pend_sd | state==HOLD), registered.

Reset
REQ-028 On reset = 1 the block SHALL set, on the next edge:
- scanlines_o = 0, scandoubler_o = SD_INIT;
- pending flags, wait counter and hold counter = 0;
- debouncer accepted levels = 1 (released), vsync history = 0;
- FSM = HOLD, so core_reset_o = 1 and busy_o = 1.
REQ-029 After reset deasserts, core_reset_o SHALL remain 1 for exactly RESET_HOLD cycles.
REQ-030 A reset arriving mid-operation SHALL discard pending requests and partially debounced presses.

Verification (DEBOUNCE_CYCLES=4, RESET_HOLD=8, VS_TIMEOUT=100, SD_INIT=1)
REQ-031 Power-on: reset high 2 cycles, then low -> core_reset_o = 1 for 8 cycles then 0; scanlines_o = 0; scandoubler_o = 1.
REQ-032 Wrap: 4 kbd_scanlines_i pulses, each followed by one vs_i edge -> scanlines_o goes 1, 2, 3, 0; each update lands 1 cycle after the vs_i edge.
REQ-033 Collapse and simultaneity: 3 kbd_scanlines_i pulses plus 1 kbd_scandbl_i pulse before one vs_i edge -> scanlines_o +1 and scandoubler_o 1->0 on the same cycle; busy_o falls with them.
REQ-034 Debounce: btn_n_i[0] low for 3 cycles -> no change; low for 6 cycles then vs_i edge -> scanlines_o +1; a 2-cycle bounce high mid-press -> no second request.
REQ-035 Timeout: kbd_scandbl_i with vs_i held 0 -> scandoubler_o toggles after 100 cycles.
REQ-036 Reset retrigger: kbd_reset_i, then again 5 cycles later -> core_reset_o high for 13 cycles total.
